// File: rtl/mode7_pkg.sv
// Shared types and default widths for the Mode7 affine line engine.
package mode7_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP1 = 2'd1,
        SETUP2 = 2'd2,
        RUN    = 2'd3
    } state_t;

    localparam int DEF_COORD_W = 16;
    localparam int DEF_FRAC_W  = 8;
    localparam int DEF_TEX_XW  = 6;
    localparam int DEF_TEX_YW  = 6;
    localparam int DEF_COLOR_W = 8;
    localparam int DEF_LINE_W  = 640;
    localparam int PIX_X_W     = 11;

    localparam logic [DEF_COLOR_W-1:0] DEF_FILL_COLOR = '1;

    // Fixed-point 1.0 in coefficient units.
    localparam int ONE = 1 << DEF_FRAC_W;

    // Accumulator width: integer part, fraction, plus two guard bits so the
    // sum of two products and the origin term has headroom before wrapping.
    function automatic int acc_width(input int coord_w, input int frac_w);
        return coord_w + frac_w + 2;
    endfunction

endpackage

// File: rtl/mode7_line_engine_if.sv
// Texture-ROM read port and output pixel stream of the Mode7 line engine.
// master = engine side, slave = ROM / line-buffer side.
interface mode7_line_engine_if import mode7_pkg::*; #(
    parameter int TEX_AW  = DEF_TEX_XW + DEF_TEX_YW,
    parameter int COLOR_W = DEF_COLOR_W
);
    logic               tex_rd;
    logic [TEX_AW-1:0]  tex_addr;
    logic [COLOR_W-1:0] tex_data;
    logic               pix_valid;
    logic               pix_ready;
    logic [COLOR_W-1:0] pix_color;
    logic [PIX_X_W-1:0] pix_x;
    logic               pix_last;

    modport master (
        output tex_rd, tex_addr,
        input  tex_data,
        output pix_valid, pix_color, pix_x, pix_last,
        input  pix_ready
    );

    modport slave (
        input  tex_rd, tex_addr,
        output tex_data,
        input  pix_valid, pix_color, pix_x, pix_last,
        output pix_ready
    );
endinterface

// File: rtl/mode7_line_setup.sv
// Per-line start coordinate: latches the line parameters on load, registers
// the four matrix products one cycle later, and presents the start sums
// combinationally from those products two cycles after load.
module mode7_line_setup import mode7_pkg::*; #(
    parameter  int COORD_W = DEF_COORD_W,
    parameter  int FRAC_W  = DEF_FRAC_W,
    localparam int CW      = COORD_W + FRAC_W,
    localparam int ACC_W   = acc_width(COORD_W, FRAC_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic signed [COORD_W-1:0] line_y,
    input  logic signed [COORD_W-1:0] origin_x,
    input  logic signed [COORD_W-1:0] origin_y,
    input  logic signed [COORD_W-1:0] offset_x,
    input  logic signed [COORD_W-1:0] offset_y,
    input  logic signed [CW-1:0]      coef_a,
    input  logic signed [CW-1:0]      coef_b,
    input  logic signed [CW-1:0]      coef_c,
    input  logic signed [CW-1:0]      coef_d,
    output logic signed [CW-1:0]      step_a,
    output logic signed [CW-1:0]      step_c,
    output logic signed [ACC_W-1:0]   start_x,
    output logic signed [ACC_W-1:0]   start_y
);
    logic signed [COORD_W-1:0] ly_q, ly_d, ox_q, ox_d, oy_q, oy_d, offx_q, offx_d, offy_q, offy_d;
    logic signed [CW-1:0]      a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic signed [COORD_W:0]   dx, dy;
    logic signed [ACC_W-1:0]   pax_q, pax_d, pby_q, pby_d, pcx_q, pcx_d, pdy_q, pdy_d;

    // Capture the line parameters only on the accept cycle.
    always_comb begin
        ly_d = ly_q; ox_d = ox_q; oy_d = oy_q; offx_d = offx_q; offy_d = offy_q;
        a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q;
        if (load) begin
            ly_d = line_y; ox_d = origin_x; oy_d = origin_y;
            offx_d = offset_x; offy_d = offset_y;
            a_d = coef_a; b_d = coef_b; c_d = coef_c; d_d = coef_d;
        end
    end

    // Products are only needed modulo 2^ACC_W, so multiply at accumulator width.
    always_comb begin
        dx    = (COORD_W+1)'(offx_q) - (COORD_W+1)'(ox_q);
        dy    = (COORD_W+1)'(ly_q) + (COORD_W+1)'(offy_q) - (COORD_W+1)'(oy_q);
        pax_d = ACC_W'(a_q) * ACC_W'(dx);
        pby_d = ACC_W'(b_q) * ACC_W'(dy);
        pcx_d = ACC_W'(c_q) * ACC_W'(dx);
        pdy_d = ACC_W'(d_q) * ACC_W'(dy);
    end

    // Parameter latches and product registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ly_q <= '0; ox_q <= '0; oy_q <= '0; offx_q <= '0; offy_q <= '0;
            a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
            pax_q <= '0; pby_q <= '0; pcx_q <= '0; pdy_q <= '0;
        end else begin
            ly_q <= ly_d; ox_q <= ox_d; oy_q <= oy_d; offx_q <= offx_d; offy_q <= offy_d;
            a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d;
            pax_q <= pax_d; pby_q <= pby_d; pcx_q <= pcx_d; pdy_q <= pdy_d;
        end
    end

    assign step_a  = a_q;
    assign step_c  = c_q;
    assign start_x = pax_q + pby_q + (ACC_W'(ox_q) <<< FRAC_W);
    assign start_y = pcx_q + pdy_q + (ACC_W'(oy_q) <<< FRAC_W);

endmodule

// File: rtl/mode7_line_engine.sv
// Mode7 affine line engine: FSM, stepping accumulators and the two-stage
// fetch/output pipe. Define MODE7_WRAP_EN to tile the texture instead of
// filling out-of-bounds samples with FILL_COLOR.
module mode7_line_engine import mode7_pkg::*; #(
    parameter  int COORD_W = DEF_COORD_W,
    parameter  int FRAC_W  = DEF_FRAC_W,
    parameter  int TEX_XW  = DEF_TEX_XW,
    parameter  int TEX_YW  = DEF_TEX_YW,
    parameter  int COLOR_W = DEF_COLOR_W,
    parameter  int LINE_W  = DEF_LINE_W,
    parameter  logic [COLOR_W-1:0] FILL_COLOR = '1,
    localparam int CW      = COORD_W + FRAC_W,
    localparam int ACC_W   = acc_width(COORD_W, FRAC_W)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic signed [COORD_W-1:0] line_y,
    input  logic signed [COORD_W-1:0] origin_x,
    input  logic signed [COORD_W-1:0] origin_y,
    input  logic signed [COORD_W-1:0] offset_x,
    input  logic signed [COORD_W-1:0] offset_y,
    input  logic signed [CW-1:0]      coef_a,
    input  logic signed [CW-1:0]      coef_b,
    input  logic signed [CW-1:0]      coef_c,
    input  logic signed [CW-1:0]      coef_d,
    output logic                      busy,
    output logic                      done,
    mode7_line_engine_if.master       bus
);
    state_t                 state_q, state_d;
    logic signed [ACC_W-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic signed [ACC_W-1:0] start_x, start_y;
    logic signed [CW-1:0]    step_a, step_c;
    logic [PIX_X_W-1:0]      n_q, n_d, s2_x_q, s2_x_d;
    logic                    issue_done_q, issue_done_d;
    logic                    s2_valid_q, s2_valid_d, s2_oob_q, s2_oob_d, s2_last_q, s2_last_d;
    logic                    done_q, done_d;
    logic                    accept, stall, handshake, s1_go, col_last, in_bounds;
    logic [TEX_XW-1:0]       tx_idx;
    logic [TEX_YW-1:0]       ty_idx;

    // The cycle after done is still IDLE, but a start there must be refused.
    assign accept = (state_q == IDLE) && start && !done_q;

    mode7_line_setup #(.COORD_W(COORD_W), .FRAC_W(FRAC_W)) u_setup (
        .clk(clk), .rst(rst), .load(accept),
        .line_y(line_y), .origin_x(origin_x), .origin_y(origin_y),
        .offset_x(offset_x), .offset_y(offset_y),
        .coef_a(coef_a), .coef_b(coef_b), .coef_c(coef_c), .coef_d(coef_d),
        .step_a(step_a), .step_c(step_c), .start_x(start_x), .start_y(start_y)
    );

`ifdef MODE7_WRAP_EN
    // Tiled texture: low integer bits select the texel, every sample is valid.
    always_comb begin
        tx_idx    = acc_x_q[FRAC_W +: TEX_XW];
        ty_idx    = acc_y_q[FRAC_W +: TEX_YW];
        in_bounds = 1'b1;
    end
`else
    logic signed [ACC_W-FRAC_W-1:0] tx_full, ty_full;

    // Integer coordinate is in range iff every bit above the index is zero.
    always_comb begin
        tx_full   = acc_x_q[ACC_W-1:FRAC_W];
        ty_full   = acc_y_q[ACC_W-1:FRAC_W];
        tx_idx    = tx_full[TEX_XW-1:0];
        ty_idx    = ty_full[TEX_YW-1:0];
        in_bounds = (tx_full[ACC_W-FRAC_W-1:TEX_XW] == '0) &&
                    (ty_full[ACC_W-FRAC_W-1:TEX_YW] == '0);
    end
`endif

    // Pipe control: a waiting output pixel freezes the whole pipe.
    always_comb begin
        stall     = s2_valid_q && !bus.pix_ready;
        handshake = s2_valid_q && bus.pix_ready;
        col_last  = (n_q == PIX_X_W'(LINE_W - 1));
        s1_go     = (state_q == RUN) && !issue_done_q && !stall;
    end

    // Next state: fixed two setup cycles, then run until the last pixel leaves.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETUP1;
            SETUP1:  state_d = SETUP2;
            SETUP2:  state_d = RUN;
            RUN:     if (handshake && s2_last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Accumulator stepping, column counter and S2 pipeline register updates.
    always_comb begin
        acc_x_d      = acc_x_q;
        acc_y_d      = acc_y_q;
        n_d          = n_q;
        issue_done_d = issue_done_q;
        s2_valid_d   = s2_valid_q;
        s2_oob_d     = s2_oob_q;
        s2_last_d    = s2_last_q;
        s2_x_d       = s2_x_q;
        done_d       = (state_q == RUN) && handshake && s2_last_q;
        if (accept) begin
            n_d          = '0;
            issue_done_d = 1'b0;
        end
        if (state_q == SETUP2) begin
            acc_x_d = start_x;
            acc_y_d = start_y;
        end
        if (s1_go) begin
            acc_x_d = acc_x_q + ACC_W'(step_a);
            acc_y_d = acc_y_q + ACC_W'(step_c);
            n_d     = n_q + PIX_X_W'(1);
            if (col_last) issue_done_d = 1'b1;
        end
        if (!stall) begin
            s2_valid_d = s1_go;
            s2_oob_d   = !in_bounds;
            s2_last_d  = s1_go && col_last;
            if (s1_go) s2_x_d = n_q;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Datapath registers; reset discards any in-flight pixels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_x_q <= '0; acc_y_q <= '0; n_q <= '0; issue_done_q <= 1'b0;
            s2_valid_q <= 1'b0; s2_oob_q <= 1'b0; s2_last_q <= 1'b0; s2_x_q <= '0;
            done_q <= 1'b0;
        end else begin
            acc_x_q <= acc_x_d; acc_y_q <= acc_y_d; n_q <= n_d; issue_done_q <= issue_done_d;
            s2_valid_q <= s2_valid_d; s2_oob_q <= s2_oob_d; s2_last_q <= s2_last_d; s2_x_q <= s2_x_d;
            done_q <= done_d;
        end
    end

    // The ROM holds its data while tex_rd is low, so S2 can take the colour
    // straight from tex_data even across stalls.
    assign bus.tex_rd    = s1_go && in_bounds;
    assign bus.tex_addr  = bus.tex_rd ? {ty_idx, tx_idx} : '0;
    assign bus.pix_valid = s2_valid_q;
    assign bus.pix_color = !s2_valid_q ? '0 : (s2_oob_q ? FILL_COLOR : bus.tex_data);
    assign bus.pix_x     = s2_x_q;
    assign bus.pix_last  = s2_last_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;

endmodule
